// File: rtl/busio_pkg.sv
// Shared types and widths for the busio bus-interface block.
package busio_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREG   = 4;

  // Register index as driven by the arbiter on arx.
  typedef enum logic [1:0] {
    REG_ADDR  = 2'd0,
    REG_CMD   = 2'd1,
    REG_RDATA = 2'd2,
    REG_WDATA = 2'd3
  } reg_index_t;

  // Bus cycle phase reported on the phase output.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_ADDR = 2'd1,
    PH_DATA = 2'd2
  } phase_t;

endpackage

// File: rtl/busio_parity.sv
// Odd-parity checker for captured external read data.
module busio_parity
  import busio_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_par,
  output logic              o_bad
);

  // Data plus parity bit must hold an odd number of ones.
  assign o_bad = ~(^{i_data, i_par});

endmodule

// File: rtl/busio.sv
// busio: CPU-visible register file plus external bus strobe/phase control.
// Optional feature: define BUSIO_PARITY_EN to add ext_dpar/perr parity checking.
module busio
  import busio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        arx,
  input  logic              ecx,
  input  logic              wrx,
  input  logic              astb,
  input  logic              rd,
  input  logic              wr,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_sel,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic [ADDR_W-1:0] ext_addr,
  output logic              ext_astb,
  output logic              ext_rd,
  output logic              ext_wr,
  output logic [DATA_W-1:0] ext_dout,
  input  logic [DATA_W-1:0] ext_din,
  output logic [1:0]        phase,
`ifdef BUSIO_PARITY_EN
  input  logic              ext_dpar,
  output logic              perr,
`endif
  output logic              berr
);

  localparam logic [1:0] S_IDLE = PH_IDLE;
  localparam logic [1:0] S_ADDR = PH_ADDR;
  localparam logic [1:0] S_DATA = PH_DATA;

  logic [1:0]        r_phase;
  logic [1:0]        w_phase_nxt;
  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_berr;

  logic w_astb_req;
  logic w_mid;
  logic w_clash;
  logic w_capture;
  logic w_err;

  assign w_astb_req = ecx & astb & (arx == REG_ADDR);
  assign w_mid      = (r_phase != S_IDLE);
  assign w_clash    = rd & wr;
  assign w_capture  = ecx & wrx;
  assign w_err      = (ecx & (rd | wr) & ~w_mid) | w_clash | (astb & w_mid);

  // Next-phase decode; losing the bus (ecx=0) always drops back to IDLE.
  always_comb begin
    w_phase_nxt = r_phase;
    if (!ecx) begin
      w_phase_nxt = S_IDLE;
    end else begin
      case (r_phase)
        S_IDLE:  if (w_astb_req) w_phase_nxt = S_ADDR;
        S_ADDR:  w_phase_nxt = S_DATA;
        S_DATA:  w_phase_nxt = S_DATA;
        default: w_phase_nxt = S_IDLE;
      endcase
    end
  end

  // Phase state register.
  always_ff @(posedge clk) begin
    if (reset) r_phase <= S_IDLE;
    else       r_phase <= w_phase_nxt;
  end

  // Register file: bus capture is written last so it wins over a CPU write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else begin
      if (cpu_we)    r_regs[cpu_sel] <= cpu_din;
      if (w_capture) r_regs[arx]     <= ext_din;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (reset)      r_berr <= 1'b0;
    else if (w_err) r_berr <= 1'b1;
  end

`ifdef BUSIO_PARITY_EN
  logic w_par_bad;
  logic r_perr;

  busio_parity u_parity (
    .i_data (ext_din),
    .i_par  (ext_dpar),
    .o_bad  (w_par_bad)
  );

  // Sticky parity error; the bad data is still captured.
  always_ff @(posedge clk) begin
    if (reset)                      r_perr <= 1'b0;
    else if (w_capture & w_par_bad) r_perr <= 1'b1;
  end

  assign perr = r_perr;
`endif

  // Zero-latency strobes, suppressed during reset and on protocol violations.
  assign ext_astb = ~reset & w_astb_req & ~w_mid;
  assign ext_rd   = ~reset & ecx & rd & w_mid & ~w_clash;
  assign ext_wr   = ~reset & ecx & wr & (arx == REG_WDATA) & w_mid & ~w_clash;

  assign ext_addr = r_regs[REG_ADDR][ADDR_W-1:0];
  assign ext_dout = r_regs[REG_WDATA];
  assign cpu_dout = r_regs[cpu_sel];
  assign phase    = r_phase;
  assign berr     = r_berr;

endmodule

// File: tb/tb_busio.sv
// Self-checking bench for busio: directed scenarios plus randomized traffic vs a model.
module tb_busio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  arx = '0;
  logic        ecx = 1'b0;
  logic        wrx = 1'b0;
  logic        astb = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_sel = '0;
  logic [63:0] cpu_din = '0;
  logic [63:0] cpu_dout;
  logic [19:0] ext_addr;
  logic        ext_astb;
  logic        ext_rd;
  logic        ext_wr;
  logic [63:0] ext_dout;
  logic [63:0] ext_din = '0;
  logic [1:0]  phase;
  logic        berr;
`ifdef BUSIO_PARITY_EN
  logic        ext_dpar = 1'b1;
  logic        perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (phase: 0 idle, 1 address, 2 data).
  bit [63:0] m_regs [4];
  int        m_phase = 0;
  bit        m_berr  = 1'b0;
  bit        m_perr  = 1'b0;

  busio dut (
    .clk      (clk),
    .reset    (reset),
    .arx      (arx),
    .ecx      (ecx),
    .wrx      (wrx),
    .astb     (astb),
    .rd       (rd),
    .wr       (wr),
    .cpu_we   (cpu_we),
    .cpu_sel  (cpu_sel),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .ext_addr (ext_addr),
    .ext_astb (ext_astb),
    .ext_rd   (ext_rd),
    .ext_wr   (ext_wr),
    .ext_dout (ext_dout),
    .ext_din  (ext_din),
    .phase    (phase),
`ifdef BUSIO_PARITY_EN
    .ext_dpar (ext_dpar),
    .perr     (perr),
`endif
    .berr     (berr)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit in_cycle;
    bit par_bit;
    in_cycle = (m_phase != 0);
    par_bit  = 1'b1;
`ifdef BUSIO_PARITY_EN
    par_bit  = ext_dpar;
`endif
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 64'd0;
      m_phase = 0;
      m_berr  = 1'b0;
      m_perr  = 1'b0;
    end else begin
      if ((ecx && (rd || wr) && !in_cycle) || (rd && wr) || (astb && in_cycle)) m_berr = 1'b1;
      if (cpu_we) m_regs[cpu_sel] = cpu_din;
      if (ecx && wrx) begin
        m_regs[arx] = ext_din;
        if ((($countones(ext_din) + int'(par_bit)) % 2) == 0) m_perr = 1'b1;
      end
      if (!ecx)              m_phase = 0;
      else if (m_phase == 0) m_phase = (astb && arx == 2'd0) ? 1 : 0;
      else                   m_phase = 2;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    arx = '0; ecx = 0; wrx = 0; astb = 0; rd = 0; wr = 0;
    cpu_we = 0; cpu_sel = '0; cpu_din = '0; ext_din = '0;
`ifdef BUSIO_PARITY_EN
    ext_dpar = 1'b1;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] sel, input logic [63:0] val);
    cpu_we = 1; cpu_sel = sel; cpu_din = val;
    tick();
    cpu_we = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; ecx = 1; astb = 1; rd = 1; arx = 2'd0;
    #1;
    n_checks++;
    if ({ext_astb, ext_rd, ext_wr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes got=%b exp=000", {ext_astb, ext_rd, ext_wr});
    end
    tick();
    clear_inputs();
    tick();
    reset = 0;
    #1;
    n_checks++;
    if (phase !== 2'd0 || berr !== 1'b0) begin
      n_fail++; $display("FAIL reset_state phase=%0d berr=%b exp phase=0 berr=0", phase, berr);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_sel = 2'(i);
      #1;
      n_checks++;
      if (cpu_dout !== 64'd0) begin
        n_fail++; $display("FAIL reset_reg%0d got=%h exp=0", i, cpu_dout);
      end
    end
  endtask

  task automatic test_read();
    int astb_cnt = 0;
    int rd_cnt = 0;
    do_reset();
    cpu_write(2'd0, 64'h12345);
    // step0: address strobe
    ecx = 1; astb = 1; arx = 2'd0;
    #1;
    astb_cnt += int'(ext_astb); rd_cnt += int'(ext_rd);
    n_checks++;
    if (ext_addr !== 20'h12345) begin
      n_fail++; $display("FAIL read_addr got=%h exp=12345", ext_addr);
    end
    tick();
    n_checks++;
    if (phase !== 2'd1) begin n_fail++; $display("FAIL read_phase_addr got=%0d exp=1", phase); end
    // step1: read request
    astb = 0; rd = 1;
    #1;
    astb_cnt += int'(ext_astb); rd_cnt += int'(ext_rd);
    tick();
    n_checks++;
    if (phase !== 2'd2) begin n_fail++; $display("FAIL read_phase_data got=%0d exp=2", phase); end
    // step2: capture external data into RDATA
    rd = 0; wrx = 1; arx = 2'd2; ext_din = 64'hDEADBEEF;
    #1;
    astb_cnt += int'(ext_astb); rd_cnt += int'(ext_rd);
    tick();
    // step3: visible on cpu_dout
    wrx = 0; cpu_sel = 2'd2; ecx = 0;
    #1;
    n_checks++;
    if (cpu_dout !== 64'hDEADBEEF) begin
      n_fail++; $display("FAIL read_rg2 got=%h exp=deadbeef", cpu_dout);
    end
    tick();
    n_checks++;
    if (astb_cnt != 1 || rd_cnt != 1) begin
      n_fail++; $display("FAIL read_strobe_count astb=%0d rd=%0d exp 1 1", astb_cnt, rd_cnt);
    end
    n_checks++;
    if (phase !== 2'd0 || berr !== 1'b0) begin
      n_fail++; $display("FAIL read_end phase=%0d berr=%b exp 0 0", phase, berr);
    end
  endtask

  task automatic test_write();
    int wr_cnt = 0;
    do_reset();
    cpu_write(2'd3, 64'hCAFE);
    ecx = 1; astb = 1; arx = 2'd0;
    #1; wr_cnt += int'(ext_wr);
    tick();
    astb = 0; arx = 2'd3;
    #1; wr_cnt += int'(ext_wr);
    tick();
    wr = 1;
    #1;
    n_checks++;
    if (ext_wr !== 1'b1 || ext_dout !== 64'hCAFE) begin
      n_fail++; $display("FAIL write_strobe ext_wr=%b dout=%h exp 1 cafe", ext_wr, ext_dout);
    end
    wr_cnt += int'(ext_wr);
    tick();
    wr = 0;
    #1; wr_cnt += int'(ext_wr);
    tick();
    ecx = 0;
    tick();
    n_checks++;
    if (wr_cnt != 1 || berr !== 1'b0) begin
      n_fail++; $display("FAIL write_count cnt=%0d berr=%b exp 1 0", wr_cnt, berr);
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    ecx = 1; rd = 1;
    #1;
    n_checks++;
    if (ext_rd !== 1'b0) begin n_fail++; $display("FAIL perr_rd got=%b exp=0", ext_rd); end
    tick();
    clear_inputs();
    n_checks++;
    if (berr !== 1'b1) begin n_fail++; $display("FAIL proto_berr_set got=%b exp=1", berr); end
    repeat (4) tick();
    n_checks++;
    if (berr !== 1'b1) begin n_fail++; $display("FAIL proto_berr_sticky got=%b exp=1", berr); end
    do_reset();
    n_checks++;
    if (berr !== 1'b0) begin n_fail++; $display("FAIL proto_berr_clear got=%b exp=0", berr); end
    // simultaneous rd & wr inside a cycle suppresses both strobes
    ecx = 1; astb = 1; arx = 2'd0;
    tick();
    astb = 0; arx = 2'd3; rd = 1; wr = 1;
    #1;
    n_checks++;
    if (ext_rd !== 1'b0 || ext_wr !== 1'b0) begin
      n_fail++; $display("FAIL clash_strobes rd=%b wr=%b exp 0 0", ext_rd, ext_wr);
    end
    tick();
    clear_inputs();
    n_checks++;
    if (berr !== 1'b1) begin n_fail++; $display("FAIL clash_berr got=%b exp=1", berr); end
    // address strobe mid-cycle is suppressed
    do_reset();
    ecx = 1; astb = 1; arx = 2'd0;
    tick();
    #1;
    n_checks++;
    if (ext_astb !== 1'b0) begin n_fail++; $display("FAIL midastb got=%b exp=0", ext_astb); end
    tick();
    clear_inputs();
    n_checks++;
    if (berr !== 1'b1) begin n_fail++; $display("FAIL midastb_berr got=%b exp=1", berr); end
  endtask

  task automatic test_collision();
    do_reset();
    cpu_we = 1; cpu_sel = 2'd2; cpu_din = 64'h1;
    ecx = 1; wrx = 1; arx = 2'd2; ext_din = 64'h2;
    tick();
    clear_inputs();
    cpu_sel = 2'd2;
    #1;
    n_checks++;
    if (cpu_dout !== 64'h2) begin n_fail++; $display("FAIL collision got=%h exp=2", cpu_dout); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cpu_write(2'd3, 64'h55);
    cpu_write(2'd0, 64'hABCDE);
    ecx = 1; astb = 1; arx = 2'd0;
    tick();
    astb = 0;
    tick();
    reset = 1; rd = 1; wrx = 1; arx = 2'd2; ext_din = 64'hFFFF;
    #1;
    n_checks++;
    if ({ext_astb, ext_rd, ext_wr} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_strobes got=%b exp=000", {ext_astb, ext_rd, ext_wr});
    end
    tick();
    reset = 0;
    clear_inputs();
    #1;
    n_checks++;
    if (phase !== 2'd0) begin n_fail++; $display("FAIL rstmid_phase got=%0d exp=0", phase); end
    for (int i = 0; i < 4; i++) begin
      cpu_sel = 2'(i);
      #1;
      n_checks++;
      if (cpu_dout !== 64'd0) begin
        n_fail++; $display("FAIL rstmid_reg%0d got=%h exp=0", i, cpu_dout);
      end
    end
  endtask

`ifdef BUSIO_PARITY_EN
  task automatic test_parity();
    do_reset();
    ecx = 1; wrx = 1; arx = 2'd2; ext_din = 64'h1; ext_dpar = 1'b1;
    tick();
    clear_inputs();
    cpu_sel = 2'd2;
    #1;
    n_checks++;
    if (cpu_dout !== 64'h1 || perr !== 1'b1) begin
      n_fail++; $display("FAIL parity rg2=%h perr=%b exp 1 1", cpu_dout, perr);
    end
  endtask
`endif

  task automatic test_random();
    bit mid, clash, e_astb, e_rd, e_wr;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 99) < 3);
      ecx     = ($urandom_range(0, 99) < 85);
      astb    = ($urandom_range(0, 99) < 25);
      rd      = ($urandom_range(0, 99) < 30);
      wr      = ($urandom_range(0, 99) < 30);
      wrx     = ($urandom_range(0, 99) < 30);
      arx     = 2'($urandom_range(0, 3));
      cpu_we  = ($urandom_range(0, 99) < 30);
      cpu_sel = 2'($urandom_range(0, 3));
      cpu_din = {$urandom, $urandom};
      ext_din = {$urandom, $urandom};
`ifdef BUSIO_PARITY_EN
      ext_dpar = 1'($urandom_range(0, 1));
`endif
      #1;
      mid    = (m_phase != 0);
      clash  = rd && wr;
      e_astb = !reset && ecx && astb && arx == 2'd0 && !mid;
      e_rd   = !reset && ecx && rd && mid && !clash;
      e_wr   = !reset && ecx && wr && arx == 2'd3 && mid && !clash;
      n_checks++;
      if ({ext_astb, ext_rd, ext_wr} !== {e_astb, e_rd, e_wr}) begin
        n_fail++; $display("FAIL rnd_strobes n=%0d got=%b exp=%b", n, {ext_astb, ext_rd, ext_wr}, {e_astb, e_rd, e_wr});
      end
      n_checks++;
      if (cpu_dout !== m_regs[cpu_sel] || ext_dout !== m_regs[3] || ext_addr !== m_regs[0][19:0]) begin
        n_fail++; $display("FAIL rnd_data n=%0d cpu=%h/%h dout=%h/%h addr=%h/%h", n, cpu_dout, m_regs[cpu_sel], ext_dout, m_regs[3], ext_addr, m_regs[0][19:0]);
      end
      tick();
      n_checks++;
      if (int'(phase) != m_phase || berr !== m_berr) begin
        n_fail++; $display("FAIL rnd_state n=%0d phase=%0d/%0d berr=%b/%b", n, phase, m_phase, berr, m_berr);
      end
`ifdef BUSIO_PARITY_EN
      n_checks++;
      if (perr !== m_perr) begin n_fail++; $display("FAIL rnd_perr n=%0d got=%b exp=%b", n, perr, m_perr); end
`endif
    end
    reset = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_read();
    test_write();
    test_proto_err();
    test_collision();
    test_reset_mid();
`ifdef BUSIO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/busio.md
BUSIO -- requirements
Module: busio

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high (clk, reset).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- arx  in  2  register index from the arbiter
- ecx  in  1  bus port enable from the arbiter
- wrx  in  1  capture external data into the indexed register
- astb  in  1  address strobe request
- rd  in  1  memory read request
- wr  in  1  memory write request
- cpu_we  in  1  load a register from the CPU
- cpu_sel  in  2  CPU register index
- cpu_din  in  64  CPU write data
- cpu_dout  out  64  register selected by cpu_sel
- ext_addr  out  20  physical word address
- ext_astb  out  1  external address strobe
- ext_rd  out  1  external read strobe
- ext_wr  out  1  external write strobe
- ext_dout  out  64  external write data
- ext_din  in  64  external read data
- phase  out  2  bus cycle phase
- berr  out  1  sticky protocol error

Function
REQ-003 The block SHALL hold four 64-bit registers: RG0 ADDR, RG1 CMD, RG2 RDATA, RG3 WDATA.
REQ-004 cpu_we SHALL load cpu_din into register cpu_sel at the next clock edge.
REQ-005 cpu_dout SHALL be a combinational read of register cpu_sel.
REQ-006 ext_addr SHALL equal RG0[19:0] continuously, and ext_dout SHALL equal RG3 continuously.
REQ-007 The phase FSM SHALL have the states IDLE=0, ADDR=1 and DATA=2.
REQ-008 The FSM SHALL move IDLE->ADDR on ecx & astb & arx==ADDR.
REQ-009 The FSM SHALL move ADDR->DATA on the next cycle in which ecx=1.
REQ-010 The FSM SHALL stay in DATA while ecx=1.
REQ-011 The FSM SHALL return to IDLE from any state on any cycle with ecx=0.
REQ-012 ext_astb SHALL equal ecx & astb & arx==ADDR in the same cycle, with zero latency.
REQ-013 ext_rd SHALL equal ecx & rd when phase is ADDR or DATA, with zero latency.
REQ-014 ext_wr SHALL equal ecx & wr & arx==WDATA when phase is ADDR or DATA, with zero latency.
REQ-015 ecx & wrx SHALL capture ext_din into register arx at the clock edge.
REQ-016 When a bus capture and cpu_we target the same register in the same cycle, the bus capture SHALL win.
REQ-017 ecx & (rd|wr) while phase=IDLE SHALL suppress the external strobe and set berr.
REQ-018 Simultaneous rd & wr SHALL suppress both strobes and set berr.
REQ-019 astb while phase is not IDLE SHALL suppress ext_astb and set berr.
REQ-020 berr SHALL remain set until reset.
REQ-021 Required read timing: step0 astb, step1 rd, step2 wrx captures ext_din into RG2, which is visible on cpu_dout (cpu_sel=RDATA) in step3.

Reset
REQ-022 Reset SHALL clear RG0..RG3 to 0, set phase to IDLE and clear berr.
REQ-023 During reset, all ext_* strobes SHALL be 0.
REQ-024 Reset asserted mid-cycle (in ADDR or DATA) SHALL abort the cycle with no capture and no strobe.

Configuration
REQ-025 With BUSIO_PARITY_EN defined, the block SHALL add input ext_dpar (1, odd parity of ext_din) and output perr (sticky).
REQ-026 With BUSIO_PARITY_EN defined, a capture with bad parity SHALL still load the register and SHALL set perr until reset.
REQ-027 Without BUSIO_PARITY_EN, ext_dpar and perr SHALL be absent and there SHALL be no parity logic.

Structure
REQ-028 Package busio_pkg SHALL hold the reg_index enum (ADDR=0, CMD=1, RDATA=2, WDATA=3), the phase enum (IDLE, ADDR, DATA) and the 20-bit address width constant.
REQ-029 The arbiter SHALL import reg_index from busio_pkg.
REQ-030 A sub-module busio_parity (64-bit odd-parity check) SHALL be instantiated only under BUSIO_PARITY_EN.

Verification
REQ-031 Read: RG0=0x12345; astb, rd, wrx sequence with ext_din=0xDEADBEEF -> ext_addr=0x12345, ext_astb for 1 cycle, ext_rd for 1 cycle, RG2=0xDEADBEEF, phase IDLE after ecx drops.
REQ-032 Write: RG3=0xCAFE; astb, then arx=WDATA, then wr -> ext_wr high exactly 1 cycle with ext_dout=0xCAFE, and berr=0.
REQ-033 Protocol error: rd with ecx=1 while phase=IDLE -> ext_rd=0, berr=1, berr stays 1 until reset.
REQ-034 Collision: cpu_we to RG2 with 0x1 in the wrx cycle with ext_din=0x2 -> RG2=0x2.
REQ-035 Reset in DATA phase: phase=IDLE, all registers 0, no strobe in the reset cycle.
REQ-036 Parity (BUSIO_PARITY_EN): capture with ext_din=0x1, ext_dpar=1 -> RG2=0x1 and perr=1.
